// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
package fifo_pkg;

  localparam int unsigned DEF_ADDR_W = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// Read-side handshake and status bundle of the FIFO read pointer controller.
interface rd_ptr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic              rinc;
  logic [ADDR_W:0]   rq2_wptr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr;
  logic              rempty;
  logic              raempty;
  logic [ADDR_W:0]   rlevel;
  logic              rundf;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, raempty, rlevel, rundf
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, raempty, rlevel, rundf
  );

endinterface

// File: rtl/rd_ptr_ctrl_gray2bin_conv.sv
// Parametrised Gray-to-binary converter built as an XOR prefix chain from the MSB down.
module gray2bin_conv #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin[W-1] = gray[W-1];

  for (genvar i = 0; i < W - 1; i++) begin : g_chain
    assign bin[i] = bin[i+1] ^ gray[i];
  end

endmodule

// File: rtl/rd_ptr_ctrl.sv
// Read-side pointer controller: RAM read address, Gray read pointer, empty/almost-empty/level.
// Optional sticky underflow flag enabled by defining RD_UNDERFLOW_FLAG_EN.
module rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned AEMPTY_TH = 2
) (
  input logic          rclk,
  input logic          rrst_n,
  rd_ptr_ctrl_if.slave bus
);

  localparam int unsigned PW = ADDR_W + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rgray_d;
  logic [PW-1:0] rlevel_q, lvl_d;
  logic [PW-1:0] wbin_s;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          accept;

  gray2bin_conv #(
    .W(PW)
  ) u_wptr_conv (
    .gray(bus.rq2_wptr),
    .bin (wbin_s)
  );

  // Empty/level are computed from the post-accept pointer so the last read flips empty
  // on the same edge without a bubble.
  always_comb begin
    accept    = bus.rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(accept);
    rgray_d   = PW'(bin2gray(32'(rbin_d)));
    lvl_d     = wbin_s - rbin_d;
    rempty_d  = (rgray_d == bus.rq2_wptr);
    raempty_d = (32'(lvl_d) <= AEMPTY_TH);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rgray_d;
      rlevel_q  <= lvl_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

`ifdef RD_UNDERFLOW_FLAG_EN
  logic rundf_q;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rundf_q <= 1'b0;
    end else if (bus.rinc & rempty_q) begin
      rundf_q <= 1'b1;
    end
  end

  assign bus.rundf = rundf_q;
`else
  assign bus.rundf = 1'b0;
`endif

  assign bus.raddr   = rbin_q[ADDR_W-1:0];
  assign bus.rptr    = rptr_q;
  assign bus.rempty  = rempty_q;
  assign bus.raempty = raempty_q;
  assign bus.rlevel  = rlevel_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Self-checking bench for rd_ptr_ctrl (ADDR_W=2, AEMPTY_TH=1) against a counter-based model.
module tb_rd_ptr_ctrl;

  localparam int unsigned AW    = 2;
  localparam int unsigned TH    = 1;
  localparam int unsigned DEPTH = 4;
  localparam logic [2:0] GRAY [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                      3'b110, 3'b111, 3'b101, 3'b100};

  logic rclk;
  logic rrst_n;

  rd_ptr_ctrl_if #(.ADDR_W(AW)) bus ();

  rd_ptr_ctrl #(
    .ADDR_W   (AW),
    .AEMPTY_TH(TH)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .bus   (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Model: unbounded read/write entry counts; everything else derived arithmetically.
  int         m_rcnt;
  int         m_wcnt;
  logic [1:0] e_raddr;
  logic [2:0] e_rptr;
  logic       e_empty;
  logic       e_aempty;
  logic [2:0] e_level;
  logic       e_undf;

  function automatic logic [10:0] obs();
    return {bus.raddr, bus.rptr, bus.rempty, bus.raempty, bus.rlevel, bus.rundf};
  endfunction

  function automatic logic [10:0] expv();
    return {e_raddr, e_rptr, e_empty, e_aempty, e_level, e_undf};
  endfunction

  // One clock: drive at negedge, advance the model, return #1 after the active edge.
  task automatic cycle(input bit inc, input int wc, input bit rst);
    int lvl;
    bit acc;
    @(negedge rclk);
    bus.rinc     = inc;
    bus.rq2_wptr = GRAY[wc % 8];
    rrst_n       = ~rst;
    m_wcnt       = wc;
    if (rst) begin
      m_rcnt   = 0;
      e_raddr  = '0;
      e_rptr   = '0;
      e_empty  = 1'b1;
      e_aempty = 1'b1;
      e_level  = '0;
      e_undf   = 1'b0;
    end else begin
      acc = inc && !e_empty;
`ifdef RD_UNDERFLOW_FLAG_EN
      if (inc && e_empty) e_undf = 1'b1;
`endif
      m_rcnt   = m_rcnt + int'(acc);
      lvl      = wc - m_rcnt;
      e_level  = 3'(lvl);
      e_empty  = (lvl == 0);
      e_aempty = (lvl <= int'(TH));
      e_raddr  = 2'(m_rcnt % DEPTH);
      e_rptr   = GRAY[m_rcnt % 8];
    end
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 0, 1'b1);
    cycle(1'b1, 0, 1'b1);
    checks++;
    if (obs() !== 11'b00_000_1_1_000_0) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b", obs(), 11'b00_000_1_1_000_0);
    end
    // Released with rinc held: no pointer motion, underflow per build.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0, 1'b0);
      checks++;
      if (obs() !== expv() || bus.rptr !== 3'b000 || bus.rempty !== 1'b1) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %b want %b", i, obs(), expv());
      end
    end
`ifdef RD_UNDERFLOW_FLAG_EN
    checks++;
    if (bus.rundf !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky: got %b want 1", bus.rundf);
    end
`else
    checks++;
    if (bus.rundf !== 1'b0) begin
      errors++;
      $display("FAIL underflow_off: got %b want 0", bus.rundf);
    end
`endif
    do_reset();
  endtask

  task automatic test_single();
    cycle(1'b0, 1, 1'b0);
    checks++;
    if (bus.rempty !== 1'b0 || bus.rlevel !== 3'd1 || obs() !== expv()) begin
      errors++;
      $display("FAIL single_fill: got %b want %b", obs(), expv());
    end
    cycle(1'b1, 1, 1'b0);
    checks++;
    if (bus.rempty !== 1'b1 || bus.rptr !== 3'b001 || bus.raddr !== 2'd1 ||
        obs() !== expv()) begin
      errors++;
      $display("FAIL single_read: got %b want %b", obs(), expv());
    end
    do_reset();
  endtask

  task automatic test_aempty();
    cycle(1'b0, 4, 1'b0);
    checks++;
    if (bus.rlevel !== 3'd4 || bus.raempty !== 1'b0 || obs() !== expv()) begin
      errors++;
      $display("FAIL full_level: got %b want %b", obs(), expv());
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 4, 1'b0);
    checks++;
    if (bus.rlevel !== 3'd1 || bus.raempty !== 1'b1 || bus.rempty !== 1'b0 ||
        obs() !== expv()) begin
      errors++;
      $display("FAIL aempty_th: got %b want %b", obs(), expv());
    end
    cycle(1'b1, 4, 1'b0);
    checks++;
    if (bus.rempty !== 1'b1 || bus.rlevel !== 3'd0 || obs() !== expv()) begin
      errors++;
      $display("FAIL drain_empty: got %b want %b", obs(), expv());
    end
    do_reset();
  endtask

  task automatic test_wrap();
    logic [2:0] prev;
    logic [2:0] walk [10];
    walk = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    prev = bus.rptr;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, i + 1, 1'b0);
      cycle(1'b1, i + 1, 1'b0);
      checks++;
      if (bus.rptr !== walk[i+1] || $countones(bus.rptr ^ prev) != 1 ||
          bus.rlevel > 3'd1 || obs() !== expv()) begin
        errors++;
        $display("FAIL wrap[%0d]: rptr %b want %b, level %0d, got %b want %b",
                 i, bus.rptr, walk[i+1], bus.rlevel, obs(), expv());
      end
      prev = bus.rptr;
    end
    do_reset();
  endtask

  task automatic test_random();
    int wc = 0;
    for (int i = 0; i < 400; i++) begin
      if (wc - m_rcnt <= 2 && $urandom_range(0, 7) == 0) wc += 2;
      else if (wc - m_rcnt <= 3 && $urandom_range(0, 1) == 1) wc += 1;
      cycle(1'($urandom_range(0, 1)), wc, 1'b0);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
      end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 3, 1'b0);
    cycle(1'b1, 4, 1'b0);
    checks++;
    if (bus.rlevel !== 3'd3 || obs() !== expv()) begin
      errors++;
      $display("FAIL mid_level: got %b want %b", obs(), expv());
    end
    cycle(1'b1, 4, 1'b1);
    checks++;
    if (obs() !== 11'b00_000_1_1_000_0) begin
      errors++;
      $display("FAIL mid_reset: got %b want %b", obs(), 11'b00_000_1_1_000_0);
    end
    cycle(1'b0, 0, 1'b0);
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL post_reset: got %b want %b", obs(), expv());
    end
  endtask

  initial begin
    bus.rinc     = 1'b0;
    bus.rq2_wptr = '0;
    rrst_n       = 1'b0;
    m_rcnt       = 0;
    m_wcnt       = 0;
    test_reset();
    test_single();
    test_aempty();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_ptr_ctrl.md
# rd_ptr_ctrl

Parametrised read-side pointer controller for the dual-clock FIFO, living entirely in the `rclk` domain. It generates the binary RAM read address and a registered Gray read pointer for synchronisation into the write domain. It also produces a registered empty flag, a programmable almost-empty flag and a read-side occupancy count. It consumes the write pointer already double-synchronised into `rclk`.

## Interface
- `ADDR_W`, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- `AEMPTY_TH`, 2, almost-empty threshold in entries; legal range 0..2**ADDR_W-1.

- `rclk`  in  1  read clock.
- `rrst_n`  in  1  reset, synchronous, active-low; clock `rclk`.
- `rinc`  in  1  read request; accepted only when `rempty`=0.
- `rq2_wptr`  in  ADDR_W+1  Gray write pointer, already synchronised into `rclk`.
- `raddr`  out  ADDR_W  RAM read address, `rbin[ADDR_W-1:0]`.
- `rptr`  out  ADDR_W+1  registered Gray read pointer, to write-domain synchroniser.
- `rempty`  out  1  registered empty flag.
- `raempty`  out  1  registered almost-empty flag.
- `rlevel`  out  ADDR_W+1  registered occupancy seen from read side, 0..2**ADDR_W.
- `rundf`  out  1  sticky underflow flag (see Configuration).

## Operation
- State registers: `rbin` (ADDR_W+1, binary), `rptr`, `rempty`, `raempty`, `rlevel`, `rundf`.
- Accept = `rinc & ~rempty`; `rbin_nx = rbin + accept`, modulo 2**(ADDR_W+1); MSB is the wrap bit.
- `rgray_nx = rbin_nx ^ (rbin_nx >> 1)`; `rptr <= rgray_nx`. `rptr` never comes from combinational logic, so it is glitch-free for CDC. Exactly one bit changes per accept.
- `rempty <= (rgray_nx == rq2_wptr)`. This is a look-ahead comparison, so the last read deasserts-to-asserts with no bubble.
- `wbin_s = gray2bin(rq2_wptr)`; `lvl_nx = wbin_s - rbin_nx`, modulo 2**(ADDR_W+1), so the result is correct across wrap; `rlevel <= lvl_nx`.
- `raempty <= (lvl_nx <= AEMPTY_TH)`.
- `rlevel`/`rempty` are pessimistic; write-side updates appear only after synchroniser latency. `rlevel` = 2**ADDR_W exactly when full.
- `rinc` while `rempty`=1: ignored (no pointer move). It sets `rundf` when the feature is enabled.
- Simultaneous accept and `rq2_wptr` change: both are applied in the same next-state computation.
- Reset mid-operation: all state returns to reset values on the next `rclk` edge regardless of `rinc`. The write side must be reset coherently; that is not enforced here.

## Timing
- Reset values: `rbin`=0, `raddr`=0, `rptr`=0, `rempty`=1, `raempty`=1, `rlevel`=0, `rundf`=0.
- `raddr` is valid in the cycle a read is accepted. RAM data is available per the RAM's own latency; `raddr` advances on the edge after acceptance.
- Change of `rq2_wptr` → `rempty`, `raempty`, `rlevel` update at the next `rclk` edge (1 cycle).
- Accept at edge N → `rptr`, `rempty`, `rlevel` reflect it from edge N.
- Back-to-back accepts are supported every cycle.

## Configuration
- `RD_UNDERFLOW_FLAG_EN` defined: `rundf` is set on the first `rinc & rempty` cycle and stays 1 until `rrst_n`.
- Not defined: `rundf` is tied to 0 and no register is inferred. The port remains present.

## Structure
- Shared package `fifo_pkg`: default `ADDR_W`, functions `bin2gray` and `gray2bin`. The write-side controller uses the same package.
- One sub-module: `gray2bin_conv`, a parametrised width converter for `rq2_wptr`, written as an XOR prefix chain.

## Test plan
- Reset with `rinc`=1 held → after release `rempty`=1, `raempty`=1, `rlevel`=0, `rptr`=0, no pointer motion.
- ADDR_W=2: drive `rq2_wptr`=gray(1)=3'b001, then read once → `rempty` 0 for one cycle, back to 1 at the accept edge, `rptr`=3'b001.
- ADDR_W=2, AEMPTY_TH=1: `rq2_wptr`=gray(4)=3'b110 → `rlevel`=4, `raempty`=0. After 3 reads `rlevel`=1 and `raempty`=1. After the 4th read `rempty`=1.
- Wrap: 9 write/read pairs with ADDR_W=2 → `rptr` walks 000,001,011,010,110,111,101,100,000,001 with one bit change per step; `rlevel`≤1 throughout.
- Underflow: `rinc`=1 while empty, macro on → `rundf`=1 next edge and sticky, `rbin` unchanged. Macro off → `rundf` stays 0.
- Reset asserted mid-stream at `rlevel`=3 → next edge all outputs return to reset values.
